bin_cnt_param: RTL

Parametrised synchronous binary counter, the successor to the fixed 4-bit structural counter. It generalises width and modulus and adds:
- up/down direction
- parallel load
- count enable with an integer prescaler
- wrap or saturate mode
- terminal-count and wrap indications

It serves as the general-purpose counter/timer primitive for later lab datapaths and controllers.

---
 rtl/bin_cnt_param.sv | 103 ++++++++++
 1 files changed

// File: rtl/bin_cnt_param.sv
// Parametrised up/down binary counter with prescaler, load, wrap/saturate and tc/wrap flags.
// Optional registered Gray output enabled by defining BIN_CNT_GRAY_EN.
module bin_cnt_param #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap
`ifdef BIN_CNT_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    localparam int unsigned      PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 32'd1);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             wrap_q, wrap_d;

    // Next-state: load beats step, step only when the prescaler completes its period.
    always_comb begin
        counter_d = counter_q;
        pre_d     = pre_q;
        wrap_d    = 1'b0;
        if (load) begin
            counter_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            pre_d     = '0;
        end else if (en) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                if (up) begin
                    if (counter_q == MAX_VAL) begin
                        if (!sat) begin
                            counter_d = '0;
                            wrap_d    = 1'b1;
                        end
                    end else begin
                        counter_d = counter_q + WIDTH'(1);
                    end
                end else begin
                    if (counter_q == '0) begin
                        if (!sat) begin
                            counter_d = MAX_VAL;
                            wrap_d    = 1'b1;
                        end
                    end else begin
                        counter_d = counter_q - WIDTH'(1);
                    end
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q <= '0;
            pre_q     <= '0;
            wrap_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            pre_q     <= pre_d;
            wrap_q    <= wrap_d;
        end
    end

`ifdef BIN_CNT_GRAY_EN
    logic [WIDTH-1:0] gray_q, gray_d;

    // Encoded from the next count so gray tracks counter on the same edge.
    always_comb begin
        gray_d = counter_d ^ (counter_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign gray = gray_q;
`endif

    assign counter = counter_q;
    assign wrap    = wrap_q;
    assign tc      = up ? (counter_q == MAX_VAL) : (counter_q == '0);

endmodule
